// File: rtl/laplace_pkg.sv
// laplace_pkg: shared helpers for the streaming 5-point Laplacian filter.
//   sum_w(w)     : signed width of 4e-(b+d+f+h), w+3 bits (cannot overflow)
//   cnt_w(n)     : bits needed to count 0..n-1
//   mask(x, ab)  : x with the low ab bits forced to zero (approximation)
//   DEF_*        : default geometry and the matching counter widths
package laplace_pkg;

   localparam int DEF_COLS  = 512;
   localparam int DEF_ROWS  = 512;
   localparam int DEF_COL_W = $clog2(DEF_COLS);
   localparam int DEF_ROW_W = $clog2(DEF_ROWS);

   function automatic int sum_w(input int w);
      return w + 3;
   endfunction

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [31:0] mask(input logic [31:0] x, input int ab);
      return x & ~((32'd1 << ab) - 32'd1);
   endfunction

endpackage

// File: rtl/laplace_line_buffer.sv
// laplace_line_buffer: one-row delay line built as a circular RAM.
//   clk, rst : clock, synchronous active-high reset (pointer only)
//   en       : one write + one read this cycle
//   wr_data  : pixel pushed in
//   rd_data  : pixel pushed DEPTH enables ago (valid before the write)
module laplace_line_buffer #(
   parameter int W     = 8,
   parameter int DEPTH = 512
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data
);
   localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;

   // The slot about to be overwritten holds the oldest pixel.
   assign rd_data = mem[ptr];

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (en)
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   end

   // Storage carries no reset; stale contents are never emitted.
   always_ff @(posedge clk) begin
      if (en)
         mem[ptr] <= wr_data;
   end

endmodule

// File: rtl/laplace_stream.sv
// laplace_stream: streaming 5-point Laplacian s = 4e - b - d - f - h over a
// raster-order pixel stream, emitting the (ROWS-2)x(COLS-2) interior pixels.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake, in_pixel raster order
//   out_valid/out_ready  : output handshake, out_pixel filtered result
//   out_last             : final output of a frame
// Optional build macro LAPLACE_SAT_EN: clamp the result to [0, 2^W-1];
// otherwise the result wraps modulo 2^W.
module laplace_stream
   import laplace_pkg::*;
#(
   parameter int W           = 8,
   parameter int COLS        = 512,
   parameter int ROWS        = 512,
   parameter int APPROX_BITS = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_pixel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_pixel,
   output logic         out_last
);
   localparam int S  = sum_w(W);
   localparam int CW = cnt_w(COLS);
   localparam int RW = cnt_w(ROWS);

   logic [CW-1:0] c;
   logic [RW-1:0] r;
   logic          acc, emit, last;
   logic [W-1:0]  lb0_q, lb1_q;
   logic [W-1:0]  w_h, w_e, w_d, w_b;
   logic [W-1:0]  bm, dm, em, fm, hm;
   logic [S-1:0]  tt;
   logic [W-1:0]  res;

   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;
   assign emit     = acc && (r >= RW'(2)) && (c >= CW'(2));
   assign last     = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

   // lb0 yields (r-1,c), lb1 yields (r-2,c) for the pixel being accepted.
   laplace_line_buffer #(.W(W), .DEPTH(COLS)) u_lb0 (
      .clk(clk), .rst(rst), .en(acc), .wr_data(in_pixel), .rd_data(lb0_q)
   );
   laplace_line_buffer #(.W(W), .DEPTH(COLS)) u_lb1 (
      .clk(clk), .rst(rst), .en(acc), .wr_data(lb0_q), .rd_data(lb1_q)
   );

   // Window: only the five taps the cross needs are kept. f comes straight
   // from lb0; the others are one or two accepts old.
   always_ff @(posedge clk) begin
      if (acc) begin
         w_h <= in_pixel;
         w_e <= lb0_q;
         w_d <= w_e;
         w_b <= lb1_q;
      end
   end

   assign bm = W'(mask(32'(w_b),   APPROX_BITS));
   assign dm = W'(mask(32'(w_d),   APPROX_BITS));
   assign em = W'(mask(32'(w_e),   APPROX_BITS));
   assign fm = W'(mask(32'(lb0_q), APPROX_BITS));
   assign hm = W'(mask(32'(w_h),   APPROX_BITS));

   // Two's complement in S bits; top bit is the sign.
   assign tt = {1'b0, em, 2'b00} - (S'(bm) + S'(dm) + S'(fm) + S'(hm));

`ifdef LAPLACE_SAT_EN
   always_comb begin
      res = W'(tt);
      if (tt[S-1])
         res = '0;
      else if (tt[S-2:W] != '0)
         res = '1;
   end
`else
   assign res = W'(tt);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         c <= '0;
         r <= '0;
      end else if (acc) begin
         if (c == CW'(COLS - 1)) begin
            c <= '0;
            r <= (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
         end else begin
            c <= c + 1'b1;
         end
      end
   end

   // Load wins over drain, so a result can replace one leaving the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_last  <= 1'b0;
      end else if (emit) begin
         out_valid <= 1'b1;
         out_pixel <= res;
         out_last  <= last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_laplace_stream.sv
module tb_laplace_stream;
   localparam int W    = 8;
   localparam int COLS = 5;
   localparam int ROWS = 4;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready;
   logic [7:0] in_pixel;
   logic       ir [2];
   logic       ov [2];
   logic       ol [2];
   logic [7:0] op [2];

   always #5 clk = ~clk;

   laplace_stream #(.W(W), .COLS(COLS), .ROWS(ROWS), .APPROX_BITS(0)) u_exact (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .in_pixel(in_pixel), .out_valid(ov[0]), .out_ready(out_ready),
      .out_pixel(op[0]), .out_last(ol[0])
   );
   laplace_stream #(.W(W), .COLS(COLS), .ROWS(ROWS), .APPROX_BITS(2)) u_apx (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .in_pixel(in_pixel), .out_valid(ov[1]), .out_ready(out_ready),
      .out_pixel(op[1]), .out_last(ol[1])
   );

   int n_vec = 0;
   int n_err = 0;
   int qa[$];   // expected outputs, exact instance: pixel | last<<8
   int qb[$];   // expected outputs, APPROX_BITS=2 instance
   int img [ROWS][COLS];
   int r_m, c_m;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qsz(input int k);
      return (k == 0) ? qa.size() : qb.size();
   endfunction

   function automatic int qfront(input int k);
      return (k == 0) ? qa[0] : qb[0];
   endfunction

   function automatic int msk(input int x, input int ab);
      return x - (x % (1 << ab));
   endfunction

   function automatic int lap(input int b, input int d, input int e,
                              input int f, input int h, input int ab);
      int t;
      t = 4 * msk(e, ab) - (msk(b, ab) + msk(d, ab) + msk(f, ab) + msk(h, ab));
`ifdef LAPLACE_SAT_EN
      if (t < 0) return 0;
      if (t > 255) return 255;
      return t;
`else
      return t & 255;
`endif
   endfunction

   function automatic logic [7:0] gen(input int mode, input int rr, input int cc);
      bit ctr;
      ctr = (rr == 1) && (cc == 1);
      case (mode)
         0: return 8'd100;
         1: return ctr ? 8'd200 : 8'd10;
         2: return ctr ? 8'd0   : 8'd50;
         3: return ctr ? 8'd203 : 8'd11;
         5: return ($urandom_range(0, 1) != 0) ? 8'hff : 8'h00;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Called just after a falling edge: checks outputs against the model,
   // drives the next inputs, and updates the model with the handshakes
   // that the coming rising edge will perform.
   task automatic step(input bit v, input bit rdy, input logic [7:0] pix,
                       output bit accepted);
      bit busy;
      int e;
      in_valid  = v;
      in_pixel  = pix;
      out_ready = rdy;
      #1;
      for (int k = 0; k < 2; k++) begin
         busy = (qsz(k) != 0);
         chk($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(busy));
         if (busy) begin
            chk($sformatf("out_pixel[%0d]", k), int'(op[k]), qfront(k) & 255);
            chk($sformatf("out_last[%0d]", k), int'(ol[k]), qfront(k) >> 8);
         end
         chk($sformatf("in_ready[%0d]", k), int'(ir[k]), int'(!busy || rdy));
      end
      accepted = v && (qa.size() == 0 || rdy);
      if (qa.size() != 0 && rdy) void'(qa.pop_front());
      if (qb.size() != 0 && rdy) void'(qb.pop_front());
      if (accepted) begin
         img[r_m][c_m] = int'(pix);
         if (r_m >= 2 && c_m >= 2) begin
            e = ((r_m == ROWS - 1) && (c_m == COLS - 1)) ? 256 : 0;
            qa.push_back(e | lap(img[r_m-2][c_m-1], img[r_m-1][c_m-2],
                                 img[r_m-1][c_m-1], img[r_m-1][c_m], img[r_m][c_m-1], 0));
            qb.push_back(e | lap(img[r_m-2][c_m-1], img[r_m-1][c_m-2],
                                 img[r_m-1][c_m-1], img[r_m-1][c_m], img[r_m][c_m-1], 2));
         end
         if (c_m == COLS - 1) begin
            c_m = 0;
            r_m = (r_m == ROWS - 1) ? 0 : r_m + 1;
         end else begin
            c_m = c_m + 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_pixels(input int n, input int mode, input int vp, input int rp);
      int  got = 0;
      int  guard = 0;
      bit  a;
      while (got < n && guard < 4000) begin
         step($urandom_range(0, 99) < vp, $urandom_range(0, 99) < rp,
              gen(mode, r_m, c_m), a);
         if (a) got++;
         guard++;
      end
      chk("accept_budget", got, n);
   endtask

   task automatic drain();
      int g = 0;
      bit a;
      while ((qa.size() != 0 || qb.size() != 0) && g < 50) begin
         step(1'b0, 1'b1, 8'h00, a);
         g++;
      end
      chk("drain_empty", qa.size() + qb.size(), 0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      qa.delete();
      qb.delete();
      r_m = 0;
      c_m = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_out_valid[%0d]", k), int'(ov[k]), 0);
         chk($sformatf("rst_out_pixel[%0d]", k), int'(op[k]), 0);
         chk($sformatf("rst_out_last[%0d]", k), int'(ol[k]), 0);
         chk($sformatf("rst_in_ready[%0d]", k), int'(ir[k]), 1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
      r_m = 0; c_m = 0;
      @(negedge clk);
      do_reset();

      // Directed frames: constant, point pulse, inverse pulse, masked pulse.
      run_pixels(ROWS * COLS, 0, 100, 100);
      run_pixels(ROWS * COLS, 1, 100, 100);
      run_pixels(ROWS * COLS, 2, 100, 100);
      run_pixels(ROWS * COLS, 3, 100, 100);
      drain();

      // Saturation corners, frames back to back with no gap.
      run_pixels(2 * ROWS * COLS, 5, 100, 100);
      drain();

      // Random data with bubbles and heavy backpressure.
      run_pixels(4 * ROWS * COLS, 4, 70, 30);
      drain();
      run_pixels(3 * ROWS * COLS, 4, 100, 30);
      drain();

      // Reset mid-frame with an output pending, then a fresh frame.
      run_pixels(13, 4, 100, 100);
      step(1'b0, 1'b0, 8'h00, a);
      step(1'b0, 1'b0, 8'h00, a);
      do_reset();
      run_pixels(ROWS * COLS, 4, 80, 50);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
